// File: rtl/exec_issue_ctrl.sv
// Issue control for the execute stage: register/CC scoreboard, hazard detection and branch FSM.
// Optional feature: define EXIC_WB_BYPASS_EN to let a source that retires at WB this cycle count as ready.
module exec_issue_ctrl (
    input  logic       I_CLOCK,
    input  logic       I_RESET,
    input  logic       I_DE_Valid,
    input  logic [3:0] I_Src1Idx,
    input  logic [3:0] I_Src2Idx,
    input  logic       I_Src1Used,
    input  logic       I_Src2Used,
    input  logic [3:0] I_DestRegIdx,
    input  logic       I_RegWEn,
    input  logic       I_CCWEn,
    input  logic       I_CCRead,
    input  logic       I_IsBranch,
    input  logic       I_BrResolved,
    input  logic       I_BrTaken,
    input  logic       I_WB_RegWEn,
    input  logic [3:0] I_WB_DestRegIdx,
    input  logic       I_WB_CCWEn,
    input  logic       I_GPUStallSignal,
    output logic       O_Issue_Signal,
    output logic       O_Stall_Signal,
    output logic       O_Flush,
    output logic [1:0] O_State
);

    localparam logic [1:0] ST_RUN     = 2'd0;
    localparam logic [1:0] ST_BR_WAIT = 2'd1;
    localparam logic [1:0] ST_FLUSH   = 2'd2;

    localparam logic [1:0] CNT_MAX    = 2'd3;

`ifdef EXIC_WB_BYPASS_EN
    localparam bit BYPASS_EN = 1'b1;
`else
    localparam bit BYPASS_EN = 1'b0;
`endif

    logic [1:0]  reg_cnt [16];
    logic [1:0]  cc_cnt;
    logic [1:0]  state;
    logic [1:0]  state_nxt;
    logic        flush_q;

    logic        src1_wb_hit;
    logic        src2_wb_hit;
    logic        src1_busy;
    logic        src2_busy;
    logic        cc_busy;
    logic        dest_full;
    logic        cc_full;
    logic        hazard;
    logic        issue;
    logic [15:0] reg_inc;
    logic [15:0] reg_dec;
    logic        cc_inc;
    logic        cc_dec;

    // A pending write is resolved either when the counter has drained, or (with bypass)
    // when the last outstanding write retires at WB in this very cycle.
    function automatic logic cnt_ready(input logic [1:0] cnt, input logic wb_hit);
        return (cnt == 2'd0) || (BYPASS_EN && (cnt == 2'd1) && wb_hit);
    endfunction

    // Simultaneous issue and retire cancel; the counter saturates at both ends.
    function automatic logic [1:0] cnt_next(input logic [1:0] cnt, input logic inc, input logic dec);
        logic [1:0] nxt;
        nxt = cnt;
        if (inc && !dec && (cnt != CNT_MAX))
            nxt = cnt + 2'd1;
        else if (dec && !inc && (cnt != 2'd0))
            nxt = cnt - 2'd1;
        return nxt;
    endfunction

    always_comb begin
        src1_wb_hit = I_WB_RegWEn && (I_WB_DestRegIdx == I_Src1Idx);
        src2_wb_hit = I_WB_RegWEn && (I_WB_DestRegIdx == I_Src2Idx);
        src1_busy   = I_Src1Used && !cnt_ready(reg_cnt[I_Src1Idx], src1_wb_hit);
        src2_busy   = I_Src2Used && !cnt_ready(reg_cnt[I_Src2Idx], src2_wb_hit);
        cc_busy     = I_CCRead   && !cnt_ready(cc_cnt, I_WB_CCWEn);
        dest_full   = I_RegWEn   && (reg_cnt[I_DestRegIdx] == CNT_MAX);
        cc_full     = I_CCWEn    && (cc_cnt == CNT_MAX);
        hazard      = src1_busy || src2_busy || cc_busy || dest_full || cc_full;
    end

    assign issue = (state == ST_RUN) && I_DE_Valid && !hazard && !I_GPUStallSignal && !I_RESET;

    always_comb begin
        if (I_RESET)
            O_Stall_Signal = 1'b0;
        else if (state == ST_BR_WAIT)
            O_Stall_Signal = 1'b1;
        else
            O_Stall_Signal = I_DE_Valid && !issue;
    end

    always_comb begin
        // NOTE: every combinational output gets a default first so no path can infer a latch.
        reg_inc = '0;
        reg_dec = '0;
        if (issue && I_RegWEn)
            reg_inc = 16'd1 << I_DestRegIdx;
        if (I_WB_RegWEn)
            reg_dec = 16'd1 << I_WB_DestRegIdx;
        cc_inc = issue && I_CCWEn;
        cc_dec = I_WB_CCWEn;
    end

    // Branch FSM; a stall from the GPU stage never holds it back.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_RUN: begin
                if (issue && I_IsBranch)
                    state_nxt = ST_BR_WAIT;
            end
            ST_BR_WAIT: begin
                if (I_BrResolved)
                    state_nxt = I_BrTaken ? ST_FLUSH : ST_RUN;
            end
            ST_FLUSH: state_nxt = ST_RUN;
            default:  state_nxt = ST_RUN;
        endcase
    end

    // The whole pipeline front end samples on the falling clock edge.
    always_ff @(negedge I_CLOCK) begin
        // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
        if (I_RESET) begin
            state   <= ST_RUN;
            flush_q <= 1'b0;
        end else begin
            state   <= state_nxt;
            flush_q <= (state_nxt == ST_FLUSH);
        end
    end

    always_ff @(negedge I_CLOCK) begin
        // NOTE: the counter array is architectural state (a stale count would block issue forever), so it is reset.
        if (I_RESET) begin
            for (int i = 0; i < 16; i++)
                reg_cnt[i] <= 2'd0;
            cc_cnt <= 2'd0;
        end else begin
            for (int i = 0; i < 16; i++)
                reg_cnt[i] <= cnt_next(reg_cnt[i], reg_inc[i], reg_dec[i]);
            cc_cnt <= cnt_next(cc_cnt, cc_inc, cc_dec);
        end
    end

    assign O_Issue_Signal = issue;
    assign O_Flush        = flush_q;
    assign O_State        = state;

endmodule

// File: tb/tb_exec_issue_ctrl.sv
// Scoreboard bench for exec_issue_ctrl: stimulus queues expected outputs, a posedge monitor compares them.
module tb_exec_issue_ctrl;

`ifdef EXIC_WB_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic       I_CLOCK;
    logic       I_RESET;
    logic       I_DE_Valid;
    logic [3:0] I_Src1Idx, I_Src2Idx;
    logic       I_Src1Used, I_Src2Used;
    logic [3:0] I_DestRegIdx;
    logic       I_RegWEn, I_CCWEn, I_CCRead, I_IsBranch;
    logic       I_BrResolved, I_BrTaken;
    logic       I_WB_RegWEn;
    logic [3:0] I_WB_DestRegIdx;
    logic       I_WB_CCWEn;
    logic       I_GPUStallSignal;
    logic       O_Issue_Signal, O_Stall_Signal, O_Flush;
    logic [1:0] O_State;

    typedef struct {
        string      name;
        logic [4:0] exp;   // {issue, stall, flush, state[1:0]}
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    exec_issue_ctrl dut (
        .I_CLOCK(I_CLOCK), .I_RESET(I_RESET), .I_DE_Valid(I_DE_Valid),
        .I_Src1Idx(I_Src1Idx), .I_Src2Idx(I_Src2Idx),
        .I_Src1Used(I_Src1Used), .I_Src2Used(I_Src2Used),
        .I_DestRegIdx(I_DestRegIdx), .I_RegWEn(I_RegWEn), .I_CCWEn(I_CCWEn),
        .I_CCRead(I_CCRead), .I_IsBranch(I_IsBranch),
        .I_BrResolved(I_BrResolved), .I_BrTaken(I_BrTaken),
        .I_WB_RegWEn(I_WB_RegWEn), .I_WB_DestRegIdx(I_WB_DestRegIdx),
        .I_WB_CCWEn(I_WB_CCWEn), .I_GPUStallSignal(I_GPUStallSignal),
        .O_Issue_Signal(O_Issue_Signal), .O_Stall_Signal(O_Stall_Signal),
        .O_Flush(O_Flush), .O_State(O_State)
    );

    initial I_CLOCK = 1'b0;
    always #5 I_CLOCK = ~I_CLOCK;

    // Monitor: state changes on negedge, so outputs are sampled on the opposite edge.
    always @(posedge I_CLOCK) begin
        if (sb.size() > 0) begin
            exp_t e;
            logic [4:0] act;
            e   = sb.pop_front();
            act = {O_Issue_Signal, O_Stall_Signal, O_Flush, O_State};
            n_cmp++;
            if (act !== e.exp) begin
                n_bad++;
                $display("FAIL %s: got issue=%b stall=%b flush=%b state=%0d, want issue=%b stall=%b flush=%b state=%0d",
                         e.name, act[4], act[3], act[2], act[1:0], e.exp[4], e.exp[3], e.exp[2], e.exp[1:0]);
            end
        end
    end

    task automatic start_cycle();
        @(negedge I_CLOCK);
        #1;
        I_RESET = 1'b0; I_DE_Valid = 1'b0;
        I_Src1Idx = 4'd0; I_Src2Idx = 4'd0; I_Src1Used = 1'b0; I_Src2Used = 1'b0;
        I_DestRegIdx = 4'd0; I_RegWEn = 1'b0; I_CCWEn = 1'b0; I_CCRead = 1'b0;
        I_IsBranch = 1'b0; I_BrResolved = 1'b0; I_BrTaken = 1'b0;
        I_WB_RegWEn = 1'b0; I_WB_DestRegIdx = 4'd0; I_WB_CCWEn = 1'b0;
        I_GPUStallSignal = 1'b0;
    endtask

    task automatic expect_out(input string nm, input logic iss, input logic stl,
                              input logic fl, input logic [1:0] st);
        exp_t e;
        e.name = nm;
        e.exp  = {iss, stl, fl, st};
        sb.push_back(e);
    endtask

    task automatic drv_write(input logic [3:0] d);
        I_DE_Valid = 1'b1; I_RegWEn = 1'b1; I_DestRegIdx = d;
    endtask

    task automatic drv_read(input logic [3:0] s);
        I_DE_Valid = 1'b1; I_Src1Used = 1'b1; I_Src1Idx = s;
    endtask

    task automatic drv_wb(input logic [3:0] d);
        I_WB_RegWEn = 1'b1; I_WB_DestRegIdx = d;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        I_RESET = 1'b1; I_DE_Valid = 1'b0;
        I_Src1Idx = 4'd0; I_Src2Idx = 4'd0; I_Src1Used = 1'b0; I_Src2Used = 1'b0;
        I_DestRegIdx = 4'd0; I_RegWEn = 1'b0; I_CCWEn = 1'b0; I_CCRead = 1'b0;
        I_IsBranch = 1'b0; I_BrResolved = 1'b0; I_BrTaken = 1'b0;
        I_WB_RegWEn = 1'b0; I_WB_DestRegIdx = 4'd0; I_WB_CCWEn = 1'b0;
        I_GPUStallSignal = 1'b0;

        // Reset held: no issue, no stall even with a valid instruction.
        start_cycle(); I_RESET = 1'b1; drv_write(4'd1);
        expect_out("reset_hold", 0, 0, 0, 2'd0);

        // RAW on R1, then the WB-same-cycle reader.
        start_cycle(); drv_write(4'd1);            expect_out("add_w_r1", 1, 0, 0, 2'd0);
        start_cycle(); drv_read(4'd1);             expect_out("raw_r1_stall", 0, 1, 0, 2'd0);
        start_cycle(); drv_read(4'd1); drv_wb(4'd1);
        expect_out("raw_r1_wb_same", BYP, !BYP, 0, 2'd0);
        start_cycle(); if (!BYP) drv_read(4'd1);
        expect_out("raw_r1_after_wb", !BYP, 0, 0, 2'd0);

        // GPU stall for 3 cycles while R2 retires.
        start_cycle(); drv_write(4'd2);            expect_out("w_r2", 1, 0, 0, 2'd0);
        start_cycle(); I_GPUStallSignal = 1; I_DE_Valid = 1; drv_wb(4'd2);
        expect_out("gpu_stall_1", 0, 1, 0, 2'd0);
        start_cycle(); I_GPUStallSignal = 1; I_DE_Valid = 1; expect_out("gpu_stall_2", 0, 1, 0, 2'd0);
        start_cycle(); I_GPUStallSignal = 1; I_DE_Valid = 1; expect_out("gpu_stall_3", 0, 1, 0, 2'd0);
        start_cycle(); I_DE_Valid = 1; I_Src2Used = 1; I_Src2Idx = 4'd2;
        expect_out("r2_drained", 1, 0, 0, 2'd0);

        // R5 saturation at 3 outstanding writes.
        start_cycle(); drv_write(4'd5);            expect_out("w_r5_a", 1, 0, 0, 2'd0);
        start_cycle(); drv_write(4'd5);            expect_out("w_r5_b", 1, 0, 0, 2'd0);
        start_cycle(); drv_write(4'd5);            expect_out("w_r5_c", 1, 0, 0, 2'd0);
        start_cycle(); drv_write(4'd5);            expect_out("w_r5_full", 0, 1, 0, 2'd0);
        start_cycle(); drv_write(4'd5);            expect_out("w_r5_full2", 0, 1, 0, 2'd0);
        start_cycle(); drv_write(4'd5); drv_wb(4'd5); expect_out("w_r5_full_wb", 0, 1, 0, 2'd0);
        start_cycle(); drv_write(4'd5);            expect_out("w_r5_d", 1, 0, 0, 2'd0);
        start_cycle(); drv_wb(4'd5);               expect_out("wb_r5_1", 0, 0, 0, 2'd0);
        start_cycle(); drv_wb(4'd5);               expect_out("wb_r5_2", 0, 0, 0, 2'd0);
        start_cycle(); drv_wb(4'd5);               expect_out("wb_r5_3", 0, 0, 0, 2'd0);
        start_cycle(); drv_wb(4'd5);               expect_out("wb_r5_at0", 0, 0, 0, 2'd0);
        start_cycle(); drv_write(4'd5);            expect_out("w_r5_nowrap", 1, 0, 0, 2'd0);
        start_cycle(); drv_read(4'd5);             expect_out("rd_r5_busy", 0, 1, 0, 2'd0);
        start_cycle(); drv_wb(4'd5);               expect_out("wb_r5_last", 0, 0, 0, 2'd0);
        start_cycle(); drv_read(4'd5);             expect_out("rd_r5_ready", 1, 0, 0, 2'd0);

        // Condition-code scoreboard.
        start_cycle(); I_DE_Valid = 1; I_CCWEn = 1; expect_out("cc_write", 1, 0, 0, 2'd0);
        start_cycle(); I_DE_Valid = 1; I_CCRead = 1; expect_out("cc_read_busy", 0, 1, 0, 2'd0);
        start_cycle(); I_DE_Valid = 1; I_CCRead = 1; I_WB_CCWEn = 1;
        expect_out("cc_read_wb_same", BYP, !BYP, 0, 2'd0);
        start_cycle(); if (!BYP) begin I_DE_Valid = 1; I_CCRead = 1; end
        expect_out("cc_read_after", !BYP, 0, 0, 2'd0);

        // Issue and WB to the same register cancel.
        start_cycle(); drv_write(4'd6);            expect_out("w_r6", 1, 0, 0, 2'd0);
        start_cycle(); drv_write(4'd6); drv_wb(4'd6); expect_out("w_r6_wb_same", 1, 0, 0, 2'd0);
        start_cycle(); drv_read(4'd6); drv_wb(4'd6);
        expect_out("rd_r6_wb", BYP, !BYP, 0, 2'd0);
        start_cycle(); if (!BYP) drv_read(4'd6);
        expect_out("rd_r6_after", !BYP, 0, 0, 2'd0);

        // Taken branch resolved two cycles after issue.
        start_cycle(); I_DE_Valid = 1; I_IsBranch = 1; expect_out("brp_issue", 1, 0, 0, 2'd0);
        start_cycle(); I_DE_Valid = 1;             expect_out("brw_wait", 0, 1, 0, 2'd1);
        start_cycle(); I_DE_Valid = 1; I_BrResolved = 1; I_BrTaken = 1;
        expect_out("brw_resolve_t", 0, 1, 0, 2'd1);
        start_cycle(); I_DE_Valid = 1;             expect_out("flush_pulse", 0, 1, 1, 2'd2);
        start_cycle(); I_DE_Valid = 1;             expect_out("after_flush", 1, 0, 0, 2'd0);

        // Not-taken branch.
        start_cycle(); I_DE_Valid = 1; I_IsBranch = 1; expect_out("br_nt_issue", 1, 0, 0, 2'd0);
        start_cycle(); I_DE_Valid = 1; I_BrResolved = 1; expect_out("br_nt_resolve", 0, 1, 0, 2'd1);
        start_cycle(); I_DE_Valid = 1;             expect_out("br_nt_run", 1, 0, 0, 2'd0);

        // FSM keeps moving under GPU stall.
        start_cycle(); I_DE_Valid = 1; I_IsBranch = 1; expect_out("br_g_issue", 1, 0, 0, 2'd0);
        start_cycle(); I_GPUStallSignal = 1; I_BrResolved = 1; I_BrTaken = 1;
        expect_out("br_g_resolve", 0, 1, 0, 2'd1);
        start_cycle(); I_GPUStallSignal = 1; I_DE_Valid = 1; expect_out("br_g_flush", 0, 1, 1, 2'd2);
        start_cycle(); I_DE_Valid = 1;             expect_out("br_g_run", 1, 0, 0, 2'd0);

        // Reset in BR_WAIT with two writes pending on R7.
        start_cycle(); drv_write(4'd7);            expect_out("w_r7", 1, 0, 0, 2'd0);
        start_cycle(); drv_write(4'd7); I_IsBranch = 1; expect_out("jsr_r7", 1, 0, 0, 2'd0);
        start_cycle(); I_RESET = 1; I_DE_Valid = 1; expect_out("rst_in_brw", 0, 0, 0, 2'd1);
        start_cycle(); drv_read(4'd7); I_BrResolved = 1; I_BrTaken = 1;
        expect_out("post_rst_r7", 1, 0, 0, 2'd0);
        start_cycle();                             expect_out("post_rst_noflush", 0, 0, 0, 2'd0);

        // Reset during FLUSH cuts the pulse short.
        start_cycle(); I_DE_Valid = 1; I_IsBranch = 1; expect_out("br_f_issue", 1, 0, 0, 2'd0);
        start_cycle(); I_BrResolved = 1; I_BrTaken = 1; expect_out("br_f_resolve", 0, 1, 0, 2'd1);
        start_cycle(); I_RESET = 1;                expect_out("rst_in_flush", 0, 0, 1, 2'd2);
        start_cycle();                             expect_out("post_rst_flush", 0, 0, 0, 2'd0);

        start_cycle();
        repeat (3) @(posedge I_CLOCK);
        #1;
        if (sb.size() != 0) begin
            n_bad++;
            $display("FAIL drain: %0d expectations left unchecked, want 0", sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
